// File: rtl/seven_seg_scanner_if.sv
// Display tap bundle: value and page controls in, scanned digit drive out.
interface seven_seg_scanner_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned PAGES = WIDTH / (4 * DIGITS);
  localparam int unsigned PW    = (PAGES > 1) ? $clog2(PAGES) : 1;

  logic [WIDTH-1:0]  reg_display;
  logic              auto_page;
  logic [PW-1:0]     page_sel;
  logic              blank_lz;
  logic [DIGITS-1:0] segEnable;
  logic [6:0]        outSeg;
  logic              dp;
  logic [PW-1:0]     page;

  modport master (
    output reg_display, auto_page, page_sel, blank_lz,
    input  segEnable, outSeg, dp, page
  );

  modport slave (
    input  reg_display, auto_page, page_sel, blank_lz,
    output segEnable, outSeg, dp, page
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multi-page seven-segment scan driver with frame-coherent snapshot,
// auto/manual paging, leading-zero blanking and a dp page indicator.
module seven_seg_scanner #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_CNT = 100000,
  parameter int unsigned PAGE_CNT = 500
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_scanner_if.slave  bus
);

  localparam int unsigned PAGES = WIDTH / (4 * DIGITS);
  localparam int unsigned PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned CW    = $clog2(SCAN_CNT);
  localparam int unsigned DW    = $clog2(DIGITS);
  localparam int unsigned FW    = (PAGE_CNT > 1) ? $clog2(PAGE_CNT) : 1;
  localparam int unsigned NW    = $clog2(WIDTH / 4);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t            state;
  logic [CW-1:0]     scan_cnt;
  logic [DW-1:0]     digit;
  logic [FW-1:0]     frame_cnt;
  logic [PW-1:0]     page_q;
  logic [WIDTH-1:0]  snap;

  logic              tick;
  logic [DW-1:0]     digit_nx;
  logic [FW-1:0]     frame_nx;
  logic [PW-1:0]     page_nx;
  logic [WIDTH-1:0]  snap_nx;
  logic [NW-1:0]     nib_idx;
  logic [WIDTH-1:0]  shifted;
  logic [6:0]        seg_nx;
  logic [DIGITS-1:0] en_nx;
  logic              dp_nx;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Next digit/page/snapshot; all changes happen only on a slot tick.
  always_comb begin
    tick     = (scan_cnt == CW'(SCAN_CNT - 1));
    digit_nx = digit;
    frame_nx = frame_cnt;
    page_nx  = page_q;
    snap_nx  = snap;
    if (tick) begin
      if (state == ST_IDLE) begin
        snap_nx = bus.reg_display;
      end else begin
        digit_nx = (digit == DW'(DIGITS - 1)) ? '0 : digit + 1'b1;
        if (digit == DW'(DIGITS - 1)) begin
          snap_nx = bus.reg_display;
          if (bus.auto_page) begin
            if (frame_cnt == FW'(PAGE_CNT - 1)) begin
              frame_nx = '0;
              page_nx  = (page_q == PW'(PAGES - 1)) ? '0 : page_q + 1'b1;
            end else begin
              frame_nx = frame_cnt + 1'b1;
            end
          end else begin
            frame_nx = '0;
            page_nx  = ({1'b0, bus.page_sel} > (PW + 1)'(PAGES - 1)) ?
                       PW'(PAGES - 1) : bus.page_sel;
          end
        end
      end
    end
  end

  // Segment/anode/dp image for the upcoming slot, with leading-zero blanking.
  always_comb begin
    nib_idx = NW'(page_nx) * NW'(DIGITS) + NW'(digit_nx);
    shifted = snap_nx >> {nib_idx, 2'b00};
    seg_nx  = hex7(shifted[3:0]);
    if (bus.blank_lz && (nib_idx != '0) && (shifted == '0)) begin
      seg_nx = 7'h7F;
    end
    en_nx = ~(DIGITS'(1) << digit_nx);
    dp_nx = (32'(digit_nx) == 32'(page_nx)) ? 1'b0 : 1'b1;
  end

  // State and output registers; outputs reload only on a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      scan_cnt      <= '0;
      digit         <= '0;
      frame_cnt     <= '0;
      page_q        <= '0;
      snap          <= '0;
      bus.segEnable <= '1;
      bus.outSeg    <= 7'h7F;
      bus.dp        <= 1'b1;
    end else begin
      scan_cnt  <= tick ? '0 : scan_cnt + 1'b1;
      digit     <= digit_nx;
      frame_cnt <= frame_nx;
      page_q    <= page_nx;
      snap      <= snap_nx;
      if (tick) begin
        state         <= ST_SCAN;
        bus.segEnable <= en_nx;
        bus.outSeg    <= seg_nx;
        bus.dp        <= dp_nx;
      end
    end
  end

  assign bus.page = page_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: vector table, directed corner sequences,
// then randomized traffic against a frame-level reference model.
module tb_seven_seg_scanner;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned SC = 4;
  localparam int unsigned PC = 2;
  localparam int unsigned NP = W / (4 * D);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scanner_if #(.WIDTH(W),  .DIGITS(D)) bus ();
  seven_seg_scanner_if #(.WIDTH(48), .DIGITS(D)) bus48 ();

  seven_seg_scanner #(.WIDTH(W), .DIGITS(D), .SCAN_CNT(SC), .PAGE_CNT(PC)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  seven_seg_scanner #(.WIDTH(48), .DIGITS(D), .SCAN_CNT(SC), .PAGE_CNT(PC)) u_dut48 (
    .clk(clk), .rst(rst), .bus(bus48)
  );

  int checks = 0;
  int errors = 0;
  int ecnt;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] en, input logic [6:0] seg,
                           input logic dpv, input logic pg);
    check($sformatf("%s.segEnable", tag), 64'(bus.segEnable), 64'(en));
    check($sformatf("%s.outSeg", tag),    64'(bus.outSeg),    64'(seg));
    check($sformatf("%s.dp", tag),        64'(bus.dp),        64'(dpv));
    check($sformatf("%s.page", tag),      64'(bus.page),      64'(pg));
  endtask

  // Edges since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) ecnt <= 0;
    else      ecnt <= ecnt + 1;
  end

  task automatic wait_edge(input int k);
    int guard = 0;
    while (ecnt < k) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 1000) begin
        check("wait_edge_timeout", 64'(ecnt), 64'(k));
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model: counts slots shown since release and applies the
  // per-frame snapshot and paging rules at each frame start.
  int         m_edges, m_slot, m_fop, m_page;
  logic [31:0] m_snap;
  logic [3:0]  m_en;
  logic [6:0]  m_seg;
  logic        m_dp;

  always @(posedge clk or negedge rst) begin : model
    int dg;
    int n;
    logic [31:0] sh;
    if (!rst) begin
      m_edges = 0; m_slot = -1; m_fop = 0; m_page = 0; m_snap = '0;
      m_en = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      m_edges++;
      if (m_edges % SC == 0) begin
        m_slot++;
        dg = m_slot % D;
        if (m_slot == 0) begin
          m_snap = bus.reg_display;
        end else if (dg == 0) begin
          m_snap = bus.reg_display;
          if (bus.auto_page) begin
            m_fop++;
            if (m_fop == PC) begin
              m_fop  = 0;
              m_page = (m_page + 1) % NP;
            end
          end else begin
            m_fop  = 0;
            m_page = (int'(bus.page_sel) < NP) ? int'(bus.page_sel) : NP - 1;
          end
        end
        n  = m_page * D + dg;
        sh = m_snap >> (4 * n);
        m_seg = hex_tab[sh[3:0]];
        if (bus.blank_lz && n != 0 && sh == 0) m_seg = 7'h7F;
        m_en = ~(4'b0001 << dg);
        m_dp = (dg == m_page) ? 1'b0 : 1'b1;
      end
    end
  end

  typedef struct {
    logic [31:0] val;
    logic        blz;
    logic        psel;
    logic [27:0] exp;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vt [12];

  // Basic manual page-0 scan from reset: dark latency, then d,C,b,A and wrap.
  task automatic run_basic(input string tag);
    logic [6:0] sq [4];
    int d;
    sq[0] = 7'h21; sq[1] = 7'h46; sq[2] = 7'h03; sq[3] = 7'h08;
    bus.reg_display = 32'h1234ABCD; bus.auto_page = 1'b0;
    bus.page_sel = 1'b0; bus.blank_lz = 1'b0;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      wait_edge(k);
      check_out($sformatf("%s_dark%0d", tag, k), 4'hF, 7'h7F, 1'b1, 1'b0);
    end
    for (int k = 4; k <= 20; k++) begin
      wait_edge(k);
      d = ((k - 4) / 4) % 4;
      check_out($sformatf("%s_e%0d", tag, k), ~(4'b0001 << d), sq[d],
                (d == 0) ? 1'b0 : 1'b1, 1'b0);
    end
  endtask

  initial begin : main
    int base;
    vt[0]  = '{32'h1234ABCD, 1'b0, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}};
    vt[1]  = '{32'h1234ABCD, 1'b0, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}};
    vt[2]  = '{32'h00000050, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h12, 7'h40}};
    vt[3]  = '{32'h00000050, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vt[4]  = '{32'h00000000, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vt[5]  = '{32'h00000000, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vt[6]  = '{32'h00000050, 1'b0, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}};
    vt[7]  = '{32'h12340000, 1'b1, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}};
    vt[8]  = '{32'h0000F000, 1'b1, 1'b0, {7'h0E, 7'h40, 7'h40, 7'h40}};
    vt[9]  = '{32'h0000F000, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vt[10] = '{32'h89ABCDEF, 1'b1, 1'b1, {7'h00, 7'h10, 7'h08, 7'h03}};
    vt[11] = '{32'h00700000, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}};

    bus.reg_display = '0; bus.auto_page = 1'b0; bus.page_sel = 1'b0; bus.blank_lz = 1'b0;
    bus48.reg_display = 48'h123456789ABC; bus48.auto_page = 1'b0;
    bus48.page_sel = 2'd3; bus48.blank_lz = 1'b0;

    // Reset state and first-digit latency.
    run_basic("basic");

    // Table vectors: one static value per run, all four digits of one page.
    for (int v = 0; v < 12; v++) begin
      bus.reg_display = vt[v].val; bus.blank_lz = vt[v].blz;
      bus.page_sel = vt[v].psel;   bus.auto_page = 1'b0;
      do_reset();
      base = vt[v].psel ? 20 : 4;
      for (int d = 0; d < 4; d++) begin
        wait_edge(base + 4 * d);
        check_out($sformatf("vec%0d_d%0d", v, d), ~(4'b0001 << d), vt[v].exp[7*d +: 7],
                  (d == int'(vt[v].psel)) ? 1'b0 : 1'b1, vt[v].psel);
      end
    end

    // Auto paging: two frames per page.
    bus.reg_display = 32'h1234ABCD; bus.auto_page = 1'b1; bus.page_sel = 1'b0; bus.blank_lz = 1'b0;
    do_reset();
    wait_edge(35); check("auto_e35.page", 64'(bus.page), 64'd0);
    wait_edge(36); check_out("auto_e36", 4'hE, 7'h19, 1'b1, 1'b1);
    wait_edge(40); check_out("auto_e40", 4'hD, 7'h30, 1'b0, 1'b1);
    wait_edge(67); check("auto_e67.page", 64'(bus.page), 64'd1);
    wait_edge(68); check_out("auto_e68", 4'hE, 7'h21, 1'b0, 1'b0);

    // Async reset while digit 3 of page 1 is lit, then clean restart.
    do_reset();
    wait_edge(49); check_out("pre_rst", 4'h7, 7'h79, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1 check_out("async_rst", 4'hF, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    run_basic("restart");

    // Snapshot coherence: value change mid-frame lands at next frame.
    bus.reg_display = 32'hAAAAAAAA; bus.auto_page = 1'b0; bus.page_sel = 1'b0;
    do_reset();
    wait_edge(12); check_out("tear_e12", 4'hB, 7'h08, 1'b1, 1'b0);
    wait_edge(13); bus.reg_display = 32'h55555555;
    wait_edge(16); check_out("tear_e16", 4'h7, 7'h08, 1'b1, 1'b0);
    wait_edge(20); check_out("tear_e20", 4'hE, 7'h12, 1'b0, 1'b0);

    // Manual page_sel mid-frame, plus out-of-range clamp on the 48-bit unit.
    bus.reg_display = 32'h1234ABCD; bus.page_sel = 1'b0;
    do_reset();
    wait_edge(19); check("w48_e19.page", 64'(bus48.page), 64'd0);
    wait_edge(20); check("w48_e20.page", 64'(bus48.page), 64'd2);
    check("w48_e20.outSeg", 64'(bus48.outSeg), 64'h19);
    check("w48_e20.dp", 64'(bus48.dp), 64'd1);
    wait_edge(21); bus.page_sel = 1'b1;
    wait_edge(24); check_out("psel_e24", 4'hD, 7'h46, 1'b1, 1'b0);
    wait_edge(35); check_out("psel_e35", 4'h7, 7'h08, 1'b1, 1'b0);
    wait_edge(36); check_out("psel_e36", 4'hE, 7'h19, 1'b1, 1'b1);

    // Randomized traffic against the reference model.
    bus.auto_page = 1'b0; bus.page_sel = 1'b0; bus.blank_lz = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      check($sformatf("rnd%0d.segEnable", i), 64'(bus.segEnable), 64'(m_en));
      check($sformatf("rnd%0d.outSeg", i),    64'(bus.outSeg),    64'(m_seg));
      check($sformatf("rnd%0d.dp", i),        64'(bus.dp),        64'(m_dp));
      check($sformatf("rnd%0d.page", i),      64'(bus.page),      64'(m_page));
      if ($urandom_range(0, 1) == 0) bus.reg_display = $urandom >> $urandom_range(0, 31);
      bus.blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 2) bus.auto_page = ~bus.auto_page;
      if ($urandom_range(0, 19) == 0) bus.page_sel = 1'($urandom_range(0, 1));
      if (i == 1500) rst = 1'b0;
      if (i == 1503) rst = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
